// File: rtl/add16_seq_ctrl.sv
// Wide adder sequencer: one 16-bit ripple adder time-shared LSB-first.
// Also holds the fulladder16 slice adder that the sequencer drives.
module fulladder16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c_in,
   output logic [15:0] sum,
   output logic        c_out
);

   logic [16:0] c;

   assign c[0] = c_in;

   for (genvar i = 0; i < 16; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign c_out = c[16];

endmodule

module add16_seq_ctrl #(
   parameter int WORDS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [16*WORDS-1:0] in_a,
   input  logic [16*WORDS-1:0] in_b,
   input  logic                in_cin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [16*WORDS-1:0] out_sum,
   output logic                out_cout,
   output logic                busy,
   output logic [15:0]         add_a,
   output logic [15:0]         add_b,
   output logic                add_cin,
   input  logic [15:0]         add_sum,
   input  logic                add_cout
);

   localparam int DW = 16 * WORDS;
   localparam int IW = $clog2(WORDS);
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [IW-1:0] idx;
   logic          carry;
   logic [DW-1:0] a_reg;
   logic [DW-1:0] b_reg;
   logic [DW-1:0] sum_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx     <= '0;
         carry   <= 1'b0;
         a_reg   <= '0;
         b_reg   <= '0;
         sum_reg <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= in_a;
                  b_reg <= in_b;
                  carry <= in_cin;
                  idx   <= '0;
               end
            end
            RUN: begin
               sum_reg[16*idx +: 16] <= add_sum;
               carry <= add_cout;
               idx   <= (idx == LAST) ? '0 : idx + IW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      add_a     = '0;
      add_b     = '0;
      add_cin   = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = rst_n;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            busy    = 1'b1;
            add_a   = a_reg[16*idx +: 16];
            add_b   = b_reg[16*idx +: 16];
            add_cin = carry;
            if (idx == LAST) state_nx = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Partial sums stay hidden until the whole result is ready.
   assign out_sum  = out_valid ? sum_reg : '0;
   assign out_cout = out_valid & carry;

endmodule

// File: tb/tb_add16_seq_ctrl.sv
// Bench for add16_seq_ctrl with WORDS=4 and a fulladder16 slice adder.
// Reference: wide integer addition and per-slice carries from masked sums.
module tb_add16_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        in_cin;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_sum;
   logic        out_cout;
   logic        busy;
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic        add_cin;
   logic [15:0] add_sum;
   logic        add_cout;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   add16_seq_ctrl #(.WORDS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .busy(busy),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout)
   );

   fulladder16 adder (
      .a(add_a), .b(add_b), .c_in(add_cin),
      .sum(add_sum), .c_out(add_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [64:0] obs,
                        input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] slice(input logic [63:0] v, input int k);
      logic [63:0] t;
      t = v >> (16 * k);
      return t[15:0];
   endfunction

   // Carry entering slice k: bit 16k of the sum of the low 16k bits.
   function automatic logic carry_into(input logic [63:0] a, input logic [63:0] b,
                                       input logic cin, input int k);
      logic [64:0] m;
      logic [64:0] s;
      if (k == 0) return cin;
      m = (65'h1 << (16 * k)) - 65'h1;
      s = ({1'b0, a} & m) + ({1'b0, b} & m) + 65'(cin);
      return s[16*k];
   endfunction

   task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input int stall, input string tag);
      logic [64:0] exp;
      int n;
      int lat;
      exp = {1'b0, a} + {1'b0, b} + 65'(cin);
      in_a = a;
      in_b = b;
      in_cin = cin;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      check({tag, " accept"}, 65'(in_ready), 65'd1);
      tick();
      in_valid = 1'b0;
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      in_cin = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         if (lat < 4) begin
            check($sformatf("%s add_a[%0d]", tag, lat), 65'(add_a), 65'(slice(a, lat)));
            check($sformatf("%s add_b[%0d]", tag, lat), 65'(add_b), 65'(slice(b, lat)));
            check($sformatf("%s add_cin[%0d]", tag, lat), 65'(add_cin),
                  65'(carry_into(a, b, cin, lat)));
         end
         tick();
         lat++;
      end
      check({tag, " latency"}, 65'(lat), 65'd4);
      check({tag, " result"}, {out_cout, out_sum}, exp);
      for (int i = 0; i < stall; i++) begin
         out_ready = 1'b0;
         in_valid = 1'b1;
         tick();
         check({tag, " stall valid"}, 65'(out_valid), 65'd1);
         check({tag, " stall result"}, {out_cout, out_sum}, exp);
         check({tag, " stall in_ready"}, 65'(in_ready), 65'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " valid drop"}, 65'(out_valid), 65'd0);
      check({tag, " idle ready"}, 65'(in_ready), 65'd1);
   endtask

   initial begin
      int n;
      int t0;
      int t1;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_a = '0;
      in_b = '0;
      in_cin = 1'b0;
      tick();
      tick();
      check("rst in_ready", 65'(in_ready), 65'd0);
      check("rst out_valid", 65'(out_valid), 65'd0);
      check("rst busy", 65'(busy), 65'd0);
      check("rst result", {out_cout, out_sum}, 65'd0);
      check("rst add_a", 65'(add_a), 65'd0);
      rst_n = 1'b1;
      #1;
      check("rel in_ready", 65'(in_ready), 65'd1);

      run_op(64'h3, 64'h4, 1'b0, 0, "t1");
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0, "t2");
      run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 0, "t3");
      run_op(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1, 5, "t4");
      run_op(64'd100, 64'd200, 1'b0, 0, "t4 next");

      in_a = 64'hFFFF_0000_FFFF_0000;
      in_b = 64'h0001_0000_0001_0000;
      in_cin = 1'b0;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("t5 busy before rst", 65'(busy), 65'd1);
      rst_n = 1'b0;
      tick();
      check("t5 out_valid", 65'(out_valid), 65'd0);
      check("t5 out_sum", 65'(out_sum), 65'd0);
      check("t5 busy", 65'(busy), 65'd0);
      check("t5 in_ready held", 65'(in_ready), 65'd0);
      rst_n = 1'b1;
      #1;
      check("t5 in_ready", 65'(in_ready), 65'd1);
      run_op(64'd1057, 64'd7677, 1'b1, 0, "t5 op");

      out_ready = 1'b1;
      in_valid = 1'b1;
      in_a = 64'd10;
      in_b = 64'd15;
      in_cin = 1'b0;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      t0 = cyc;
      tick();
      in_a = 64'd422;
      in_b = 64'd5673;
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      check("t6 sum0", {out_cout, out_sum}, 65'd25);
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      t1 = cyc;
      check("t6 spacing", 65'(t1 - t0), 65'd6);
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      check("t6 sum1", {out_cout, out_sum}, 65'd6095);
      tick();
      out_ready = 1'b0;

      for (int i = 0; i < 20; i++) begin
         run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
